gray_sobel: RTL and testbench

Streaming 3x3 Sobel edge detector that consumes the 8-bit luminance stream produced by the `gray` conversion stage. It accepts one raster-order pixel per valid cycle and emits one edge-magnitude pixel per accepted input, at a fixed two-cycle latency. It sits between the RGB-to-gray converter and the frame writer / display path. No backpressure: the upstream camera/VGA stream cannot stall.

---
 rtl/gray_pkg.sv | 16 +
 rtl/gray_sobel_if.sv | 16 +
 rtl/gray_line_buffer.sv | 33 +++
 rtl/gray_sobel.sv | 120 ++++++++++++
 tb/tb_gray_sobel.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared types and constants for the gray-stage streaming blocks (pixel, gradient,
// default frame geometry) plus a zero-extension helper into the gradient type.
package gray_pkg;

  typedef logic [7:0]         pix_t;
  typedef logic signed [10:0] grad_t;

  localparam int   IMG_W_DEF = 640;
  localparam int   IMG_H_DEF = 480;
  localparam pix_t SAT_MAX   = 8'd255;

  function automatic grad_t to_grad(input pix_t p);
    return grad_t'({3'b000, p});
  endfunction

endpackage

// File: rtl/gray_sobel_if.sv
// Pixel stream bundle for gray_sobel: gray input side (i*) and edge output side (o*).
// The master is the upstream/driver side, the slave is the Sobel block.
interface gray_sobel_if;
  import gray_pkg::*;

  logic iValid;
  logic iSOF;
  pix_t iGray;
  logic oValid;
  logic oSOF;
  pix_t oPix;

  modport master (output iValid, iSOF, iGray, input oValid, oSOF, oPix);
  modport slave  (input iValid, iSOF, iGray, output oValid, oSOF, oPix);

endinterface

// File: rtl/gray_line_buffer.sv
// DEPTH-deep 8-bit delay line with enable: dout is the sample written DEPTH enabled
// cycles earlier; the read of the slot being overwritten returns the old contents.
module gray_line_buffer
  import gray_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t          mem [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;

  assign dout = mem[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
    if (en) mem[ptr_q] <= din;
  end

endmodule

// File: rtl/gray_sobel.sv
// Streaming 3x3 Sobel edge magnitude over a raster gray stream, 2-cycle latency.
// Define GRAY_SOBEL_THRESH_EN to binarize the output against THRESH (0/255).
module gray_sobel
  import gray_pkg::*;
#(
  parameter int   IMG_W  = IMG_W_DEF,
  parameter int   IMG_H  = IMG_H_DEF,
  parameter pix_t THRESH = 8'd64
) (
  input logic         iCLK,
  input logic         iRST,
  gray_sobel_if.slave bus
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  function automatic logic [10:0] abs_grad(input grad_t g);
    return g[10] ? 11'(-g) : 11'(g);
  endfunction

  function automatic pix_t sat_mag(input logic [10:0] m);
    return (m > 11'd255) ? SAT_MAX : m[7:0];
  endfunction

  function automatic pix_t post_proc(input pix_t m, input pix_t thr);
`ifdef GRAY_SOBEL_THRESH_EN
    return (m >= thr) ? SAT_MAX : 8'd0;
`else
    return m;
`endif
  endfunction

  logic [XW-1:0]   x_q, x_d, cur_x;
  logic [YW-1:0]   y_q, y_d, cur_y;
  pix_t            mid_col, top_col;
  pix_t [2:0]      col;
  pix_t [2:0][1:0] win_q, win_d;
  grad_t           gx_d, gy_d, gx_p1_q, gy_p1_q;
  logic            mask_d, mask_p1_q, vld_p1_q, sof_p1_q, sof_in;
  logic [10:0]     mag_p1;
  pix_t            pix_d, pix_p2_q;
  logic            vld_p2_q, sof_p2_q;

  assign sof_in = bus.iValid & bus.iSOF;

  // Cascade: lb1 yields row y-1, lb2 yields row y-2 at the incoming column.
  gray_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk(iCLK), .rst(iRST), .en(bus.iValid), .din(bus.iGray), .dout(mid_col)
  );
  gray_line_buffer #(.DEPTH(IMG_W)) u_lb2 (
    .clk(iCLK), .rst(iRST), .en(bus.iValid), .din(mid_col), .dout(top_col)
  );

  assign col = {bus.iGray, mid_col, top_col};

  always_comb begin
    cur_x = bus.iSOF ? '0 : x_q;
    cur_y = bus.iSOF ? '0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    win_d = win_q;
    if (bus.iValid) begin
      if (cur_x == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
      for (int r = 0; r < 3; r++) win_d[r] = {col[r], win_q[r][1]};
    end
    // Window columns: win_q[.][0] = x-2, win_q[.][1] = x-1, col = x.
    gx_d = (to_grad(col[0]) - to_grad(win_q[0][0]))
         + ((to_grad(col[1]) - to_grad(win_q[1][0])) <<< 1)
         + (to_grad(col[2]) - to_grad(win_q[2][0]));
    gy_d = (to_grad(win_q[2][0]) + (to_grad(win_q[2][1]) <<< 1) + to_grad(col[2]))
         - (to_grad(win_q[0][0]) + (to_grad(win_q[0][1]) <<< 1) + to_grad(col[0]));
    mask_d = (cur_x < XW'(2)) || (cur_y < YW'(2));
  end

  // ---- stage 1 -> stage 2 boundary ----
  always_comb begin
    mag_p1 = abs_grad(gx_p1_q) + abs_grad(gy_p1_q);
    pix_d  = mask_p1_q ? 8'd0 : post_proc(sat_mag(mag_p1), THRESH);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_q      <= '0;
      y_q      <= '0;
      vld_p1_q <= 1'b0;
      sof_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      sof_p2_q <= 1'b0;
      pix_p2_q <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      vld_p1_q <= bus.iValid;
      sof_p1_q <= sof_in;
      vld_p2_q <= vld_p1_q;
      sof_p2_q <= sof_p1_q;
      pix_p2_q <= pix_d;
    end
  end

  // Datapath registers carry no reset; the border mask hides stale contents.
  always_ff @(posedge iCLK) begin
    win_q     <= win_d;
    gx_p1_q   <= gx_d;
    gy_p1_q   <= gy_d;
    mask_p1_q <= mask_d;
  end

  assign bus.oValid = vld_p2_q;
  assign bus.oSOF   = sof_p2_q;
  assign bus.oPix   = pix_p2_q;

endmodule

// File: tb/tb_gray_sobel.sv
// Scoreboard bench for gray_sobel on an 8x6 frame: a frame-array Sobel model feeds
// an expected-output queue that a free-running monitor drains on every oValid.
`timescale 1ns/1ps
module tb_gray_sobel;
  import gray_pkg::*;

  localparam int   W  = 8;
  localparam int   H  = 6;
  localparam pix_t TH = 8'd64;
`ifdef GRAY_SOBEL_THRESH_EN
  localparam int RAMP5_NZ = 0;
`else
  localparam int RAMP5_NZ = 24;
`endif

  typedef struct {
    pix_t pix;
    bit   sof;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_sobel_if bus();

  gray_sobel #(.IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   obs_nz = 0;
  int   midx = 0;
  int   img [H][W];
  exp_t sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_pix(input int x, input int y);
    int gx, gy, mag;
    if (x < 2 || y < 2) return 0;
    gx = (img[y-2][x] - img[y-2][x-2]) + 2 * (img[y-1][x] - img[y-1][x-2])
       + (img[y][x] - img[y][x-2]);
    gy = (img[y][x-2] + 2 * img[y][x-1] + img[y][x])
       - (img[y-2][x-2] + 2 * img[y-2][x-1] + img[y-2][x]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
`ifdef GRAY_SOBEL_THRESH_EN
    return (mag >= 64) ? 255 : 0;
`else
    return mag;
`endif
  endfunction

  task automatic check_eq(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      bus.iValid = 1'b0;
      bus.iSOF   = 1'b0;
    end
  endtask

  task automatic push_pixel(input pix_t p, input bit sof);
    int x, y;
    step();
    bus.iValid = 1'b1;
    bus.iSOF   = sof;
    bus.iGray  = p;
    if (sof) midx = 0;
    x = midx % W;
    y = midx / W;
    img[y][x] = int'(p);
    sb.push_back('{pix: pix_t'(ref_pix(x, y)), sof: sof, due: cyc + 2});
    midx = (midx + 1) % (W * H);
  endtask

  // pat: 0 flat 100, 1 vertical step, 2 ramp 10*x, 3 ramp 5*x, 4 random
  task automatic frame(input int pat, input bit with_sof, input bit gaps, input int npix);
    int   pos, x;
    pix_t v;
    for (int i = 0; i < npix; i++) begin
      pos = (with_sof && i == 0) ? 0 : midx;
      x   = pos % W;
      case (pat)
        0:       v = 8'd100;
        1:       v = (x < 4) ? 8'd0 : 8'd200;
        2:       v = pix_t'(10 * x);
        3:       v = pix_t'(5 * x);
        default: v = pix_t'($urandom_range(0, 255));
      endcase
      push_pixel(v, with_sof && i == 0);
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic do_reset(input int n);
    step();
    rst        = 1'b1;
    bus.iValid = 1'b0;
    bus.iSOF   = 1'b0;
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    for (int k = 1; k < n; k++) begin
      step();
      check_eq("rst_oValid", int'(bus.oValid), 0);
      check_eq("rst_oSOF", int'(bus.oSOF), 0);
      check_eq("rst_oPix", int'(bus.oPix), 0);
    end
    step();
    rst  = 1'b0;
    midx = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_out: no oValid at cycle %0d, required pix %0d", sb[0].due, sb[0].pix);
        void'(sb.pop_front());
      end
      if (bus.oValid === 1'b1) begin
        if (bus.oPix != 8'd0) obs_nz++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: oValid at cycle %0d pix %0d, required none", cyc, bus.oPix);
        end else begin
          e = sb.pop_front();
          if (e.due != cyc || bus.oPix != e.pix || bus.oSOF != e.sof) begin
            n_bad++;
            $display("FAIL out_pix: got pix %0d sof %0d at cycle %0d, required pix %0d sof %0d at cycle %0d",
                     bus.oPix, bus.oSOF, cyc, e.pix, e.sof, e.due);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.iValid = 1'b0;
    bus.iSOF   = 1'b0;
    bus.iGray  = 8'd0;
    do_reset(3);
    idle(2);

    obs_nz = 0; frame(0, 1'b1, 1'b0, W * H); idle(4);
    check_eq("flat_nonzero", obs_nz, 0);

    obs_nz = 0; frame(1, 1'b1, 1'b0, W * H); idle(4);
    check_eq("step_nonzero", obs_nz, 8);

    obs_nz = 0; frame(2, 1'b1, 1'b0, W * H); idle(4);
    check_eq("ramp10_nonzero", obs_nz, 24);

    obs_nz = 0; frame(2, 1'b1, 1'b1, W * H); idle(4);
    check_eq("ramp10_gaps_nonzero", obs_nz, 24);

    obs_nz = 0; frame(3, 1'b1, 1'b0, W * H); idle(4);
    check_eq("ramp5_nonzero", obs_nz, RAMP5_NZ);

    frame(4, 1'b1, 1'b1, W * H);
    frame(4, 1'b1, 1'b1, W * H);
    idle(4);

    // Two frames back to back, the second relying on counter wrap instead of iSOF.
    obs_nz = 0; frame(2, 1'b1, 1'b0, W * H); frame(2, 1'b0, 1'b0, W * H); idle(4);
    check_eq("wrap_nonzero", obs_nz, 48);

    frame(4, 1'b1, 1'b0, 13);
    obs_nz = 0; frame(1, 1'b1, 1'b0, W * H); idle(4);
    check_eq("restart_step_nonzero", obs_nz, 8);

    frame(4, 1'b1, 1'b0, 20);
    do_reset(2);
    obs_nz = 0; frame(0, 1'b0, 1'b0, W * H); idle(4);
    check_eq("post_reset_flat_nonzero", obs_nz, 0);

    idle(4);
    check_eq("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
